regfile_sb: RTL and testbench

Parametrised general-purpose register file with a per-register scoreboard for the multi-cycle and pipelined CPU datapaths. Two read ports and one write port. Byte-lane write enables, optional same-cycle write-to-read bypass, a hardwired-zero register 0, and a registered debug show port. The scoreboard tracks registers with an outstanding producer. It raises a hazard flag to the control unit whenever a read operand is still pending.

---
 rtl/regfile_sb_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 73 +++++++
 rtl/regfile_sb.sv | 101 ++++++++++
 tb/tb_regfile_sb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared CPU register-file package.
// Holds the default register-file geometry and the byte-lane merge helper
// used by the write port and the write-to-read bypass.
package regfile_sb_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  // byte_merge works on the widest supported word. Callers zero-extend their
  // operands and truncate the result back to their own width.
  localparam int MERGE_MAX_W  = 256;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  // Lane k of the result comes from new_data when be[k] is set, else old_data.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_data,
    input logic [MERGE_MAX_W-1:0]  new_data,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_data;
    for (int k = 0; k < MERGE_MAX_BE; k++) begin
      if (be[k]) res[8*k +: 8] = new_data[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard for the register file.
// One pending bit per register; a reserve sets it, a write clears it, and a
// coincident reserve+write to the same register leaves it set.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   wr_en, wr_addr       qualified write (wr_en already excludes register 0)
//   rsv_en, rsv_addr     reserve request
//   rd_addr_a/b          read addresses to look up
//   hazard_a/b           operand still pending this cycle
//   pend_cnt             number of pending registers (from registered state)
module regfile_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   pend_reg;
  logic [NREG-1:0]   pend_next;
  logic [ADDR_W-1:0] rd_addr [2];
  logic              hazard  [2];

  // Clear first, then set: a new producer reserved in the same cycle
  // supersedes the one that is completing.
  always_comb begin
    pend_next = pend_reg;
    if (wr_en) pend_next[wr_addr] = 1'b0;
    if (rsv_en && (rsv_addr != '0)) pend_next[rsv_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  // With bypass, a read of the register being written sees the completing
  // producer's data, so it only stalls if a new producer reserves it now.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
      logic bypass_hit;
      assign bypass_hit = (BYPASS != 0) && wr_en && (rd_addr[gi] == wr_addr);
      assign hazard[gi] = bypass_hit ? (rsv_en && (rsv_addr == rd_addr[gi]))
                                     : pend_reg[rd_addr[gi]];
    end
  endgenerate

  assign hazard_a = hazard[0];
  assign hazard_b = hazard[1];

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt = pend_cnt + (ADDR_W+1)'(pend_reg[i]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with per-register scoreboard.
// Two combinational read ports, one byte-masked write port, optional
// same-cycle write-to-read bypass, hardwired-zero register 0 and a
// registered debug show port.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   R_addr_A/B, rdata_A/B      read ports (combinational)
//   hazard_A/B                 read operand has an outstanding producer
//   L_S, Wt_addr, Wt_data, Wt_be  write port with byte enables
//   rsv_en, rsv_addr           reserve a register for a new producer
//   pend_cnt                   number of pending registers
//   Show_Addr, Reg_Show        debug port, one-cycle latency
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   R_addr_A,
  input  logic [ADDR_W-1:0]   R_addr_B,
  output logic [DATA_W-1:0]   rdata_A,
  output logic [DATA_W-1:0]   rdata_B,
  output logic                hazard_A,
  output logic                hazard_B,
  input  logic                L_S,
  input  logic [ADDR_W-1:0]   Wt_addr,
  input  logic [DATA_W-1:0]   Wt_data,
  input  logic [DATA_W/8-1:0] Wt_be,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [ADDR_W:0]     pend_cnt,
  input  logic [ADDR_W-1:0]   Show_Addr,
  output logic [DATA_W-1:0]   Reg_Show
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [NREG];
  logic [DATA_W-1:0] show_reg;
  logic              wr_en;
  logic [DATA_W-1:0] wr_merged;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  // Register 0 is never written, so its pending bit and storage stay zero.
  assign wr_en = L_S && (Wt_addr != '0);

  // Merged word for the write address; used for the store and the bypass.
  assign wr_merged = DATA_W'(byte_merge(MERGE_MAX_W'(mem_reg[Wt_addr]),
                                        MERGE_MAX_W'(Wt_data),
                                        MERGE_MAX_BE'(Wt_be)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_reg[i] <= '0;
      show_reg <= '0;
    end else begin
      if (wr_en) mem_reg[Wt_addr] <= wr_merged;
      // Captures the pre-write value of this edge.
      show_reg <= (Show_Addr == '0) ? '0 : mem_reg[Show_Addr];
    end
  end

  assign rd_addr[0] = R_addr_A;
  assign rd_addr[1] = R_addr_B;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      logic bypass_hit;
      assign bypass_hit  = (BYPASS != 0) && wr_en && (rd_addr[gi] == Wt_addr);
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                           bypass_hit          ? wr_merged :
                                                 mem_reg[rd_addr[gi]];
    end
  endgenerate

  assign rdata_A  = rd_data[0];
  assign rdata_B  = rd_data[1];
  assign Reg_Show = show_reg;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (Wt_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rd_addr_a (R_addr_A),
    .rd_addr_b (R_addr_B),
    .hazard_a  (hazard_A),
    .hazard_b  (hazard_B),
    .pend_cnt  (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb. Two instances share all inputs: one
// with BYPASS=1 (suffix 1) and one with BYPASS=0 (suffix 0). A directed table
// covers the listed scenarios; a randomized phase is checked against a
// behavioural model of the register file and scoreboard.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  R_addr_A, R_addr_B, Wt_addr, rsv_addr, Show_Addr;
  logic        L_S, rsv_en;
  logic [31:0] Wt_data;
  logic [3:0]  Wt_be;

  logic [31:0] rdata_A1, rdata_B1, Reg_Show1, rdata_A0, rdata_B0, Reg_Show0;
  logic        hazard_A1, hazard_B1, hazard_A0, hazard_B0;
  logic [5:0]  pend_cnt1, pend_cnt0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .rdata_A(rdata_A1), .rdata_B(rdata_B1), .hazard_A(hazard_A1), .hazard_B(hazard_B1),
    .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .Wt_be(Wt_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt1),
    .Show_Addr(Show_Addr), .Reg_Show(Reg_Show1));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .rdata_A(rdata_A0), .rdata_B(rdata_B0), .hazard_A(hazard_A0), .hazard_B(hazard_B0),
    .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .Wt_be(Wt_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_cnt0),
    .Show_Addr(Show_Addr), .Reg_Show(Reg_Show0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  // Expected values describe the outputs seen during the row's cycle,
  // i.e. before the edge that samples the row's inputs.
  typedef struct {
    int          rst, ls, wa;
    logic [31:0] wd;
    int          be, rsv, rsa, ra, rb, sh, chk;
    logic [31:0] ea1, ea0, eb1, eb0;
    int          eha1, eha0, ehb1, ehb0, ecnt;
    logic [31:0] eshow;
  } vec_t;

  localparam int NROW = 24;
  vec_t tbl [NROW];

  task automatic drive(input int r, input int ls, input int wa, input logic [31:0] wd,
                       input int be, input int rsv, input int rsa, input int ra,
                       input int rb, input int sh);
    rst       = 1'(r);
    L_S       = 1'(ls);
    Wt_addr   = 5'(wa);
    Wt_data   = wd;
    Wt_be     = 4'(be);
    rsv_en    = 1'(rsv);
    rsv_addr  = 5'(rsa);
    R_addr_A  = 5'(ra);
    R_addr_B  = 5'(rb);
    Show_Addr = 5'(sh);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  logic [31:0] m_show;

  function automatic logic [31:0] stored(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_mem[a];
  endfunction

  function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    return res;
  endfunction

  function automatic int pend_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  task automatic model_check(input int cyc);
    logic        hit_a, hit_b;
    logic [31:0] mrg;
    mrg   = merge_ref(stored(Wt_addr), Wt_data, Wt_be);
    hit_a = L_S && (Wt_addr != 5'd0) && (R_addr_A == Wt_addr);
    hit_b = L_S && (Wt_addr != 5'd0) && (R_addr_B == Wt_addr);
    chk($sformatf("rnd%0d rdata_A byp", cyc), rdata_A1, hit_a ? mrg : stored(R_addr_A));
    chk($sformatf("rnd%0d rdata_B byp", cyc), rdata_B1, hit_b ? mrg : stored(R_addr_B));
    chk($sformatf("rnd%0d rdata_A nob", cyc), rdata_A0, stored(R_addr_A));
    chk($sformatf("rnd%0d rdata_B nob", cyc), rdata_B0, stored(R_addr_B));
    chk($sformatf("rnd%0d hazard_A byp", cyc), 32'(hazard_A1),
        32'(hit_a ? (rsv_en && rsv_addr == R_addr_A) : m_pend[R_addr_A]));
    chk($sformatf("rnd%0d hazard_B byp", cyc), 32'(hazard_B1),
        32'(hit_b ? (rsv_en && rsv_addr == R_addr_B) : m_pend[R_addr_B]));
    chk($sformatf("rnd%0d hazard_A nob", cyc), 32'(hazard_A0), 32'(m_pend[R_addr_A]));
    chk($sformatf("rnd%0d hazard_B nob", cyc), 32'(hazard_B0), 32'(m_pend[R_addr_B]));
    chk($sformatf("rnd%0d pend_cnt byp", cyc), 32'(pend_cnt1), 32'(pend_count()));
    chk($sformatf("rnd%0d pend_cnt nob", cyc), 32'(pend_cnt0), 32'(pend_count()));
    chk($sformatf("rnd%0d Reg_Show byp", cyc), Reg_Show1, m_show);
    chk($sformatf("rnd%0d Reg_Show nob", cyc), Reg_Show0, m_show);
  endtask

  // Applies this cycle's sampled inputs to the model (called at the edge).
  task automatic model_update();
    logic [31:0] mrg;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'd0;
        m_pend[i] = 1'b0;
      end
      m_show = 32'd0;
    end else begin
      mrg    = merge_ref(stored(Wt_addr), Wt_data, Wt_be);
      m_show = stored(Show_Addr);
      if (L_S && Wt_addr != 5'd0) begin
        m_mem[Wt_addr]  = mrg;
        m_pend[Wt_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
    end
  endtask

  initial begin
    //         rst ls wa wd            be   rsv rsa ra  rb sh chk ea1           ea0           eb1           eb0           ha1 ha0 hb1 hb0 cnt show
    tbl[0]  = '{1, 0, 0, 32'h0,        0,   0, 0,  5,  0, 0,  0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{0, 0, 0, 32'h0,        0,   0, 0,  5,  0, 0,  1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[2]  = '{0, 1, 5, 32'hDEADBEEF, 15,  0, 0,  5,  0, 0,  1, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[3]  = '{1, 0, 0, 32'h0,        0,   0, 0,  5,  0, 5,  1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[4]  = '{0, 0, 0, 32'h0,        0,   0, 0,  5,  0, 5,  1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[5]  = '{0, 1, 3, 32'h11223344, 15,  0, 0,  3,  0, 0,  1, 32'h11223344, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[6]  = '{0, 1, 3, 32'hAABBCCDD, 5,   0, 0,  3,  0, 0,  1, 32'h11BB33DD, 32'h11223344, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[7]  = '{0, 1, 0, 32'hFFFFFFFF, 15,  1, 0,  0,  3, 0,  1, 32'h0,        32'h0,        32'h11BB33DD, 32'h11BB33DD, 0, 0, 0, 0, 0, 32'h0};
    tbl[8]  = '{0, 0, 0, 32'h0,        0,   0, 0,  0,  3, 3,  1, 32'h0,        32'h0,        32'h11BB33DD, 32'h11BB33DD, 0, 0, 0, 0, 0, 32'h0};
    tbl[9]  = '{0, 1, 7, 32'h00000010, 15,  0, 0,  7,  0, 0,  1, 32'h10,       32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h11BB33DD};
    tbl[10] = '{0, 1, 7, 32'h12345678, 3,   0, 0,  7,  0, 0,  1, 32'h5678,     32'h10,       32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[11] = '{0, 0, 0, 32'h0,        0,   1, 4,  7,  9, 0,  1, 32'h5678,     32'h5678,     32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[12] = '{0, 0, 0, 32'h0,        0,   1, 9,  4,  9, 0,  1, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 1, 32'h0};
    tbl[13] = '{0, 1, 9, 32'h99,       15,  1, 9,  4,  9, 0,  1, 32'h0,        32'h0,        32'h99,       32'h0,        1, 1, 1, 1, 2, 32'h0};
    tbl[14] = '{0, 1, 9, 32'h0,        0,   0, 0,  4,  9, 0,  1, 32'h0,        32'h0,        32'h99,       32'h99,       1, 1, 0, 1, 2, 32'h0};
    tbl[15] = '{0, 1, 4, 32'h44,       1,   0, 0,  4,  9, 0,  1, 32'h44,       32'h0,        32'h99,       32'h99,       0, 1, 0, 0, 1, 32'h0};
    tbl[16] = '{0, 1, 12, 32'h12,      15,  0, 0,  4,  0, 0,  1, 32'h44,       32'h44,       32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[17] = '{0, 0, 0, 32'h0,        0,   0, 0,  12, 0, 12, 1, 32'h12,       32'h12,       32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[18] = '{0, 1, 12, 32'hCAFE0000, 15, 0, 0,  12, 0, 12, 1, 32'hCAFE0000, 32'h12,       32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h12};
    tbl[19] = '{0, 0, 0, 32'h0,        0,   0, 0,  12, 0, 12, 1, 32'hCAFE0000, 32'hCAFE0000, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h12};
    tbl[20] = '{0, 0, 0, 32'h0,        0,   0, 0,  12, 0, 0,  1, 32'hCAFE0000, 32'hCAFE0000, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'hCAFE0000};
    tbl[21] = '{0, 0, 0, 32'h0,        0,   0, 0,  12, 0, 0,  1, 32'hCAFE0000, 32'hCAFE0000, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[22] = '{1, 1, 12, 32'h11111111, 15, 1, 6,  12, 6, 0,  1, 32'h11111111, 32'hCAFE0000, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
    tbl[23] = '{0, 0, 0, 32'h0,        0,   0, 0,  12, 6, 0,  1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};

    drive(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NROW; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].ls, tbl[i].wa, tbl[i].wd, tbl[i].be,
            tbl[i].rsv, tbl[i].rsa, tbl[i].ra, tbl[i].rb, tbl[i].sh);
      #2;
      if (tbl[i].chk != 0) begin
        chk($sformatf("row%0d rdata_A byp", i), rdata_A1, tbl[i].ea1);
        chk($sformatf("row%0d rdata_A nob", i), rdata_A0, tbl[i].ea0);
        chk($sformatf("row%0d rdata_B byp", i), rdata_B1, tbl[i].eb1);
        chk($sformatf("row%0d rdata_B nob", i), rdata_B0, tbl[i].eb0);
        chk($sformatf("row%0d hazard_A byp", i), 32'(hazard_A1), 32'(tbl[i].eha1));
        chk($sformatf("row%0d hazard_A nob", i), 32'(hazard_A0), 32'(tbl[i].eha0));
        chk($sformatf("row%0d hazard_B byp", i), 32'(hazard_B1), 32'(tbl[i].ehb1));
        chk($sformatf("row%0d hazard_B nob", i), 32'(hazard_B0), 32'(tbl[i].ehb0));
        chk($sformatf("row%0d pend_cnt byp", i), 32'(pend_cnt1), 32'(tbl[i].ecnt));
        chk($sformatf("row%0d pend_cnt nob", i), 32'(pend_cnt0), 32'(tbl[i].ecnt));
        chk($sformatf("row%0d Reg_Show byp", i), Reg_Show1, tbl[i].eshow);
        chk($sformatf("row%0d Reg_Show nob", i), Reg_Show0, tbl[i].eshow);
      end
      $display("row %0d: rst=%0d L_S=%0d Wt=%0d rsv=%0d/%0d A=%0d:%h B=%0d:%h cnt=%0d show=%h",
               i, rst, L_S, Wt_addr, rsv_en, rsv_addr, R_addr_A, rdata_A1,
               R_addr_B, rdata_B1, pend_cnt1, Reg_Show1);
    end

    // Randomized phase. The first cycle resets so the model starts aligned.
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_show = 32'd0;

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive((c == 0 || $urandom_range(0, 49) == 0) ? 1 : 0,
            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
            int'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3) ? 1 : 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      #2;
      model_check(c);
      $display("rnd %0d: rst=%0d L_S=%0d Wt=%0d be=%h rsv=%0d/%0d A=%0d:%h B=%0d:%h cnt=%0d",
               c, rst, L_S, Wt_addr, Wt_be, rsv_en, rsv_addr, R_addr_A, rdata_A1,
               R_addr_B, rdata_B1, pend_cnt1);
      @(posedge clk);
      model_update();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
